accel_loader: RTL and testbench
===============================

# accel_loader

Host-side front end for the convolution accelerator. It consumes an 18-bit command stream over a valid/ready handshake, writes image and filter words into accelerator memory, and latches the accelerator's static configuration. It then runs the accelerator by releasing its reset and waiting for `done`. It is the writer/controller for the memory and configuration that the accelerator reads.

## Interface

Parameters:
- `ADDR_W`, 16: memory address width; matches the accelerator's memory offsets.
- `DATA_W`, 18: stream and memory word width; matches `filter_bias`.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: the host presents a stream word.
- `in_ready` out 1: the loader accepts the word. A word transfers when `in_valid` and `in_ready` are both high on a rising edge.
- `in_data` in DATA_W: stream word.
- `mem_we` out 1: memory write strobe.
- `mem_addr` out ADDR_W: write address.
- `mem_wdata` out DATA_W: write data.
- `image_dim` out 8, `image_depth` out 9, `image_memory_offset` out 16, `filter_memory_offset` out 16, `filter_halfsize` out 2, `filter_stride` out 3, `filter_length` out 13, `filter_bias` out 18: registered accelerator configuration.
- `accel_rst` out 1: reset driven to the accelerator. High holds it idle.
- `accel_done` in 1: the accelerator's `done`.
- `busy` out 1: a command is in progress (any state other than HDR).
- `run_done` out 1: one-cycle pulse when a RUN command completes.
- `err` out 1: sticky error flag. It is cleared only by `rst`.

## Operation

- Opcode is `in_data[3:0]` of the header word. The other header bits are ignored.
  - 0x1 = LOAD, 0x2 = CONFIG, 0x3 = RUN.
  - Any other opcode sets `err`, the word is discarded, and the state stays HDR.
- States: HDR, ADDR, LEN, DATA, CFG, CHK, RUN.
- LOAD: HDR → ADDR → LEN → DATA → HDR.
  - The ADDR word gives the base address, `in_data[15:0]`.
  - The LEN word gives the count N, `in_data[15:0]`.
  - The DATA state accepts N words. Word i is written to `base+i`, modulo 2^16 (wraps silently).
  - If N=0, go from LEN directly to HDR (or to CHK when checksum is enabled).
- CONFIG: HDR → CFG. CFG accepts 6 words, then returns to HDR. Fields are loaded into a shadow copy, and all configuration outputs update together on acceptance of word 6.
  - w1: `image_dim`=[7:0], `filter_halfsize`=[9:8], `filter_stride`=[12:10].
  - w2: `image_depth`=[8:0].
  - w3: `image_memory_offset`=[15:0].
  - w4: `filter_memory_offset`=[15:0].
  - w5: `filter_length`=[12:0].
  - w6: `filter_bias`=[17:0].
- RUN: HDR → RUN. `accel_rst` drops on the cycle after the header is accepted.
  - When `accel_done` is sampled high in RUN: `accel_rst` returns to 1, `run_done` pulses, and the state goes to HDR, all on the next edge.
  - `accel_done` outside RUN is ignored.
- `in_ready` is 1 in HDR, ADDR, LEN, DATA, CFG and CHK, and 0 in RUN and during reset.

## Timing

- Reset values: `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, all configuration outputs 0, `accel_rst`=1, `busy`=0, `run_done`=0, `err`=0, state HDR. `in_ready` rises the cycle after `rst` falls.
- Memory writes are registered. `mem_we`, `mem_addr` and `mem_wdata` are valid for exactly one cycle, on the cycle after a DATA handshake. Back-to-back handshakes produce back-to-back writes, so throughput is one word per cycle.
- Host stalls (`in_valid`=0) hold the state and counters. `mem_we`=0 during stalls.
- Configuration outputs are stable while `accel_rst`=0. No CONFIG can be accepted during RUN.
- `rst` in any state (including mid-LOAD or mid-RUN):
  - aborts the command;
  - sets `accel_rst` to 1 on the next edge;
  - discards any partial CONFIG, and configuration outputs go to 0.
- Minimum RUN length is 2 cycles: header accepted, then `accel_done` already high on the next cycle.

## Configuration

- `ACCEL_LOADER_CHECKSUM_EN` defined:
  - LOAD keeps an 18-bit wrapping sum of its payload words.
  - After the last DATA word (or directly after LEN when N=0), the state goes to CHK.
  - CHK accepts one trailer word. If it differs from the sum, `err` is set.
  - Writes are never suppressed.
- Macro undefined: there is no CHK state and no trailer word; DATA returns directly to HDR.

## Structure

- Shared header `accel_defs.v` holds:
  - opcode defines;
  - state encodings;
  - configuration field widths, shared with the accelerator.
- Natural sub-module `accel_cfg_regs`: shadow registers, word-index counter, and the atomic commit of the 8 configuration outputs.

## Test plan

- LOAD base=0, N=3, data 7,8,9 streamed back to back → writes mem[0]=7, mem[1]=8, mem[2]=9 on 3 consecutive cycles.
- LOAD base=0xFFFF, N=2, with `in_valid` gapped 1 cycle → writes mem[0xFFFF] and then mem[0x0000], with no write during the gap.
- CONFIG with the words for dim=5, depth=3, offsets 0/1000, halfsize=1, stride=1, length=27, bias=100 → all outputs change on the same edge after w6, not before.
- RUN with `accel_done` asserted 20 cycles after the header → `accel_rst` low for 20 cycles, one `run_done` pulse, `in_ready`=0 throughout.
- Header opcode 0x9, then a valid LOAD → `err`=1, and the LOAD completes normally.
- `rst` during DATA word 2 of 4, then LOAD N=1 → no further old writes, and the new write lands at the new base. With the checksum macro defined, a wrong trailer sets `err`.

Source files
------------

// File: rtl/accel_loader_pkg.sv
// Shared definitions for accel_loader: opcodes, state encodings, configuration field widths.
package accel_loader_pkg;

  localparam logic [3:0] OP_LOAD   = 4'h1;
  localparam logic [3:0] OP_CONFIG = 4'h2;
  localparam logic [3:0] OP_RUN    = 4'h3;

  localparam logic [2:0] ST_HDR  = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_LEN  = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_CFG  = 3'd4;
  localparam logic [2:0] ST_CHK  = 3'd5;
  localparam logic [2:0] ST_RUN  = 3'd6;

  localparam int IMAGE_DIM_W     = 8;
  localparam int IMAGE_DEPTH_W   = 9;
  localparam int MEM_OFFSET_W    = 16;
  localparam int FILTER_HALF_W   = 2;
  localparam int FILTER_STRIDE_W = 3;
  localparam int FILTER_LEN_W    = 13;
  localparam int FILTER_BIAS_W   = 18;

  typedef struct packed {
    logic [IMAGE_DIM_W-1:0]     image_dim;
    logic [IMAGE_DEPTH_W-1:0]   image_depth;
    logic [MEM_OFFSET_W-1:0]    image_memory_offset;
    logic [MEM_OFFSET_W-1:0]    filter_memory_offset;
    logic [FILTER_HALF_W-1:0]   filter_halfsize;
    logic [FILTER_STRIDE_W-1:0] filter_stride;
    logic [FILTER_LEN_W-1:0]    filter_length;
    logic [FILTER_BIAS_W-1:0]   filter_bias;
  } cfg_t;

  // Wrapping payload sum used by the LOAD trailer check.
  function automatic logic [FILTER_BIAS_W-1:0] csum_add(input logic [FILTER_BIAS_W-1:0] acc,
                                                       input logic [FILTER_BIAS_W-1:0] w);
    return acc + w;
  endfunction

endpackage

// File: rtl/accel_loader_cfg_regs.sv
// Configuration shadow registers: collects the six CONFIG words and commits all fields on one edge.
module accel_loader_cfg_regs
  import accel_loader_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic [FILTER_BIAS_W-1:0] data,
  output logic                     last,
  output cfg_t                     cfg
);

  logic [2:0] idx_r;
  cfg_t       shadow_r;
  cfg_t       cfg_r;
  cfg_t       commit_s;

  assign last = (idx_r == 3'd5);
  assign cfg  = cfg_r;

  // The final word carries the bias, so merge it with the shadow for the single commit.
  always_comb begin
    commit_s             = shadow_r;
    commit_s.filter_bias = data;
  end

  // Word-index counter, shadow capture and atomic commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r    <= 3'd0;
      shadow_r <= '0;
      cfg_r    <= '0;
    end else if (wr) begin
      case (idx_r)
        3'd0: begin
          shadow_r.image_dim       <= data[7:0];
          shadow_r.filter_halfsize <= data[9:8];
          shadow_r.filter_stride   <= data[12:10];
        end
        3'd1: shadow_r.image_depth          <= data[8:0];
        3'd2: shadow_r.image_memory_offset  <= data[15:0];
        3'd3: shadow_r.filter_memory_offset <= data[15:0];
        3'd4: shadow_r.filter_length        <= data[12:0];
        3'd5: cfg_r                         <= commit_s;
        default: ;
      endcase
      idx_r <= last ? 3'd0 : idx_r + 3'd1;
    end
  end

endmodule

// File: rtl/accel_loader.sv
// Command-stream front end for the convolution accelerator: memory loads, configuration, run control.
// Optional feature: define ACCEL_LOADER_CHECKSUM_EN to require a summed trailer word after each LOAD.
module accel_loader
  import accel_loader_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        image_dim,
  output logic [8:0]        image_depth,
  output logic [15:0]       image_memory_offset,
  output logic [15:0]       filter_memory_offset,
  output logic [1:0]        filter_halfsize,
  output logic [2:0]        filter_stride,
  output logic [12:0]       filter_length,
  output logic [17:0]       filter_bias,
  output logic              accel_rst,
  input  logic              accel_done,
  output logic              busy,
  output logic              run_done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
`ifdef ACCEL_LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_LOAD_END = ST_CHK;
`else
  localparam logic [2:0] ST_LOAD_END = ST_HDR;
`endif

  logic [2:0]        state_r;
  logic [2:0]        state_nxt_s;
  logic              hs_s;
  logic              in_ready_r;
  logic              busy_r;
  logic [ADDR_W-1:0] addr_r;
  logic [15:0]       cnt_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic              accel_rst_r;
  logic              run_done_r;
  logic              err_r;
  logic              cfg_wr_s;
  logic              cfg_last_s;
  cfg_t              cfg_s;
`ifdef ACCEL_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_r;
`endif

  assign hs_s     = in_valid & in_ready_r;
  assign cfg_wr_s = hs_s & (state_r == ST_CFG);

  accel_loader_cfg_regs u_cfg (
    .clk  (clk),
    .rst  (rst),
    .wr   (cfg_wr_s),
    .data (in_data),
    .last (cfg_last_s),
    .cfg  (cfg_s)
  );

  // Next-state decode; every transition other than RUN completion waits for a handshake.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_HDR: begin
        case (in_data[3:0])
          OP_LOAD:   state_nxt_s = hs_s ? ST_ADDR : ST_HDR;
          OP_CONFIG: state_nxt_s = hs_s ? ST_CFG  : ST_HDR;
          OP_RUN:    state_nxt_s = hs_s ? ST_RUN  : ST_HDR;
          default:   state_nxt_s = ST_HDR;
        endcase
      end
      ST_ADDR: state_nxt_s = hs_s ? ST_LEN : ST_ADDR;
      ST_LEN:  state_nxt_s = !hs_s ? ST_LEN :
                             ((in_data[15:0] == 16'd0) ? ST_LOAD_END : ST_DATA);
      ST_DATA: state_nxt_s = (hs_s && (cnt_r == 16'd1)) ? ST_LOAD_END : ST_DATA;
      ST_CFG:  state_nxt_s = (hs_s && cfg_last_s) ? ST_HDR : ST_CFG;
`ifdef ACCEL_LOADER_CHECKSUM_EN
      ST_CHK:  state_nxt_s = hs_s ? ST_HDR : ST_CHK;
`endif
      ST_RUN:  state_nxt_s = accel_done ? ST_HDR : ST_RUN;
      default: state_nxt_s = ST_HDR;
    endcase
  end

  // Command sequencing, registered memory writes, run control and error tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_HDR;
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      addr_r      <= '0;
      cnt_r       <= 16'd0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      accel_rst_r <= 1'b1;
      run_done_r  <= 1'b0;
      err_r       <= 1'b0;
`ifdef ACCEL_LOADER_CHECKSUM_EN
      sum_r       <= '0;
`endif
    end else begin
      state_r    <= state_nxt_s;
      in_ready_r <= (state_nxt_s != ST_RUN);
      busy_r     <= (state_nxt_s != ST_HDR);
      mem_we_r   <= 1'b0;
      run_done_r <= 1'b0;
      case (state_r)
        ST_HDR: begin
          if (hs_s) begin
            case (in_data[3:0])
              OP_LOAD: begin
`ifdef ACCEL_LOADER_CHECKSUM_EN
                sum_r <= '0;
`endif
              end
              OP_CONFIG: ;
              OP_RUN:    accel_rst_r <= 1'b0;
              default:   err_r       <= 1'b1;
            endcase
          end
        end
        ST_ADDR: if (hs_s) addr_r <= in_data[ADDR_W-1:0];
        ST_LEN:  if (hs_s) cnt_r  <= in_data[15:0];
        ST_DATA: begin
          if (hs_s) begin
            mem_we_r    <= 1'b1;
            mem_addr_r  <= addr_r;
            mem_wdata_r <= in_data;
            addr_r      <= addr_r + ADDR_ONE;
            cnt_r       <= cnt_r - 16'd1;
`ifdef ACCEL_LOADER_CHECKSUM_EN
            sum_r       <= csum_add(sum_r, in_data);
`endif
          end
        end
`ifdef ACCEL_LOADER_CHECKSUM_EN
        ST_CHK: if (hs_s && (in_data != sum_r)) err_r <= 1'b1;
`endif
        ST_RUN: begin
          if (accel_done) begin
            accel_rst_r <= 1'b1;
            run_done_r  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready             = in_ready_r;
  assign busy                 = busy_r;
  assign mem_we               = mem_we_r;
  assign mem_addr             = mem_addr_r;
  assign mem_wdata            = mem_wdata_r;
  assign accel_rst            = accel_rst_r;
  assign run_done             = run_done_r;
  assign err                  = err_r;
  assign image_dim            = cfg_s.image_dim;
  assign image_depth          = cfg_s.image_depth;
  assign image_memory_offset  = cfg_s.image_memory_offset;
  assign filter_memory_offset = cfg_s.filter_memory_offset;
  assign filter_halfsize      = cfg_s.filter_halfsize;
  assign filter_stride        = cfg_s.filter_stride;
  assign filter_length        = cfg_s.filter_length;
  assign filter_bias          = cfg_s.filter_bias;

endmodule

// File: tb/tb_accel_loader.sv
// Self-checking bench for accel_loader: a word-role queue model checked every cycle, plus literal scenarios.
module tb_accel_loader;

  localparam logic [3:0] OPL = 4'h1;
  localparam logic [3:0] OPC = 4'h2;
  localparam logic [3:0] OPR = 4'h3;
  localparam int R_ADDR = 1, R_LEN = 2, R_DATA = 3, R_CFG = 4, R_CHK = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        accel_done = 1'b0;
  logic [17:0] in_data = 18'd0;
  logic        in_ready, mem_we, accel_rst, busy, run_done, err;
  logic [15:0] mem_addr;
  logic [17:0] mem_wdata;
  logic [7:0]  image_dim;
  logic [8:0]  image_depth;
  logic [15:0] image_memory_offset, filter_memory_offset;
  logic [1:0]  filter_halfsize;
  logic [2:0]  filter_stride;
  logic [12:0] filter_length;
  logic [17:0] filter_bias;

  accel_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .image_dim(image_dim), .image_depth(image_depth),
    .image_memory_offset(image_memory_offset), .filter_memory_offset(filter_memory_offset),
    .filter_halfsize(filter_halfsize), .filter_stride(filter_stride),
    .filter_length(filter_length), .filter_bias(filter_bias),
    .accel_rst(accel_rst), .accel_done(accel_done), .busy(busy),
    .run_done(run_done), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit started = 1'b0;

  logic [15:0] wl_addr[$];
  logic [17:0] wl_data[$];
  int          wl_cyc[$];
  logic [17:0] pay[$];

  // Reference model: each accepted word is interpreted by the role queued for it.
  int          roles[$];
  logic [15:0] m_addr;
  logic [17:0] m_sum;
  logic [17:0] m_cw[6];
  int          m_cn;
  bit          m_run;
  logic        e_ready = 1'b0, e_we = 1'b0, e_arst = 1'b1, e_rdone = 1'b0, e_err = 1'b0;
  logic [15:0] e_addr;
  logic [17:0] e_wdata;
  logic [7:0]  e_dim;
  logic [8:0]  e_depth;
  logic [15:0] e_ioff, e_foff;
  logic [1:0]  e_half;
  logic [2:0]  e_stride;
  logic [12:0] e_flen;
  logic [17:0] e_bias;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin : model
    logic        hs;
    logic [17:0] w;
    int          r;
    hs = in_valid && e_ready;
    w  = in_data;
    cyc++;
    e_we    = 1'b0;
    e_rdone = 1'b0;
    if (rst) begin
      started = 1'b1;
      roles.delete();
      m_run = 1'b0; m_cn = 0;
      e_ready = 1'b0; e_arst = 1'b1; e_err = 1'b0;
      e_addr = 16'd0; e_wdata = 18'd0;
      e_dim = 8'd0; e_depth = 9'd0; e_ioff = 16'd0; e_foff = 16'd0;
      e_half = 2'd0; e_stride = 3'd0; e_flen = 13'd0; e_bias = 18'd0;
    end else begin
      if (m_run && accel_done) begin
        m_run   = 1'b0;
        e_rdone = 1'b1;
      end
      if (hs) begin
        if (roles.size() == 0) begin
          case (w[3:0])
            OPL: begin roles.push_back(R_ADDR); roles.push_back(R_LEN); m_sum = 18'd0; end
            OPC: begin for (int i = 0; i < 6; i++) roles.push_back(R_CFG); m_cn = 0; end
            OPR: m_run = 1'b1;
            default: e_err = 1'b1;
          endcase
        end else begin
          r = roles.pop_front();
          case (r)
            R_ADDR: m_addr = w[15:0];
            R_LEN: begin
              for (int i = 0; i < int'(w[15:0]); i++) roles.push_back(R_DATA);
`ifdef ACCEL_LOADER_CHECKSUM_EN
              roles.push_back(R_CHK);
`endif
            end
            R_DATA: begin
              e_we = 1'b1; e_addr = m_addr; e_wdata = w;
              m_addr = m_addr + 16'd1;
              m_sum  = m_sum + w;
            end
            R_CHK: if (w != m_sum) e_err = 1'b1;
            default: begin
              m_cw[m_cn] = w;
              m_cn++;
              if (m_cn == 6) begin
                e_dim = m_cw[0][7:0]; e_half = m_cw[0][9:8]; e_stride = m_cw[0][12:10];
                e_depth = m_cw[1][8:0]; e_ioff = m_cw[2][15:0]; e_foff = m_cw[3][15:0];
                e_flen = m_cw[4][12:0]; e_bias = m_cw[5];
              end
            end
          endcase
        end
      end
      e_ready = !m_run;
      e_arst  = !m_run;
    end
  end

  // Per-cycle comparison against the model, plus a log of observed writes.
  always @(negedge clk) begin
    if (started) begin
      if (mem_we === 1'b1) begin
        wl_addr.push_back(mem_addr);
        wl_data.push_back(mem_wdata);
        wl_cyc.push_back(cyc);
      end
      chk("in_ready", in_ready, e_ready);
      chk("mem_we", mem_we, e_we);
      if (e_we) begin
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
      end
      chk("busy", busy, (roles.size() != 0) || m_run);
      chk("accel_rst", accel_rst, e_arst);
      chk("run_done", run_done, e_rdone);
      chk("err", err, e_err);
      chk("cfg", {image_dim, image_depth, image_memory_offset, filter_memory_offset,
                  filter_halfsize, filter_stride, filter_length},
                 {e_dim, e_depth, e_ioff, e_foff, e_half, e_stride, e_flen});
      chk("filter_bias", filter_bias, e_bias);
    end
  end

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  function automatic int pick_gap(input int m);
    if (m == 0) return 0;
    else if (m == 1) return 1;
    else return int'($urandom_range(0, 2));
  endfunction

  task automatic send(input logic [17:0] w, input int gap);
    bit acc;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      in_valid   = 1'b0;
      in_data    = 18'($urandom);
      accel_done = 1'($urandom);
    end
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      in_valid   = 1'b1;
      in_data    = w;
      accel_done = 1'($urandom);
      acc        = in_ready;
      @(posedge clk);
      if (acc) begin
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    errors++;
    checks++;
    $display("FAIL send_timeout: word %0h not accepted within 100 cycles, required acceptance", w);
    in_valid = 1'b0;
  endtask

  task automatic load(input logic [15:0] base, input int gmode, input bit bad_trl);
    logic [17:0] s;
    logic [17:0] trl;
    s = 18'd0;
    send({14'($urandom), OPL}, pick_gap(gmode));
    send({2'($urandom), base}, pick_gap(gmode));
    send({2'($urandom), 16'(pay.size())}, pick_gap(gmode));
    foreach (pay[i]) begin
      send(pay[i], pick_gap(gmode));
      s = s + pay[i];
    end
    trl = bad_trl ? (s ^ 18'h00001) : s;
`ifdef ACCEL_LOADER_CHECKSUM_EN
    send(trl, pick_gap(gmode));
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; accel_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int s;
    int low, pulses, badrdy, d, sel;
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int s, low, pulses, badrdy, d, sel;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_accel_rst", accel_rst, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_mem", {mem_we, mem_addr, mem_wdata}, 35'd0);
    chk("rst_cfg", {image_dim, image_depth, filter_bias}, 35'd0);
    rst = 1'b0;
    settle();
    chk("ready_after_rst", in_ready, 1'b1);

    // LOAD base 0, three words back to back.
    s = wl_addr.size();
    pay = '{18'd7, 18'd8, 18'd9};
    load(16'h0000, 0, 1'b0);
    settle();
    chk("b2b_count", wl_addr.size() - s, 3);
    if (wl_addr.size() >= s + 3) begin
      chk("b2b_addr", {wl_addr[s], wl_addr[s+1], wl_addr[s+2]}, 48'h0000_0001_0002);
      chk("b2b_data", {wl_data[s], wl_data[s+1], wl_data[s+2]}, {18'd7, 18'd8, 18'd9});
      chk("b2b_cycles", wl_cyc[s+2] - wl_cyc[s], 2);
    end

    // LOAD at top of memory with a one-cycle host gap: address wraps.
    s = wl_addr.size();
    pay = '{18'h01111, 18'h02222};
    load(16'hFFFF, 1, 1'b0);
    settle();
    chk("wrap_count", wl_addr.size() - s, 2);
    if (wl_addr.size() >= s + 2) begin
      chk("wrap_addr", {wl_addr[s], wl_addr[s+1]}, 32'hFFFF_0000);
      chk("wrap_gap", wl_cyc[s+1] - wl_cyc[s], 2);
    end

    // CONFIG: nothing changes until the sixth word.
    do_reset();
    send({14'd0, OPC}, 0);
    send(18'h00505, 0);
    send(18'd3, 0);
    send(18'd0, 0);
    send(18'd1000, 0);
    send(18'd27, 0);
    settle();
    chk("cfg_hold", {image_dim, filter_length, filter_memory_offset}, 37'd0);
    send(18'd100, 0);
    settle();
    chk("cfg_dim", image_dim, 8'd5);
    chk("cfg_depth", image_depth, 9'd3);
    chk("cfg_offsets", {image_memory_offset, filter_memory_offset}, {16'd0, 16'd1000});
    chk("cfg_half_stride", {filter_halfsize, filter_stride}, {2'd1, 3'd1});
    chk("cfg_len_bias", {filter_length, filter_bias}, {13'd27, 18'd100});

    // RUN with done sampled 20 cycles after the header.
    send({14'd0, OPR}, 0);
    low = 0; pulses = 0; badrdy = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      accel_done = (c == 20);
      if (accel_rst == 1'b0) low++;
      if (run_done == 1'b1) pulses++;
      if (accel_rst == 1'b0 && in_ready == 1'b1) badrdy++;
    end
    chk("run_low_cycles", low, 20);
    chk("run_done_pulses", pulses, 1);
    chk("run_ready_low", badrdy, 0);

    // Unknown opcode, then a normal LOAD.
    send(18'h3FFF9, 0);
    settle();
    chk("badop_err", err, 1'b1);
    chk("badop_idle", {busy, in_ready}, 2'b01);
    pay = '{18'd3};
    load(16'h0010, 0, 1'b0);
    settle();
    chk("badop_load", {wl_addr[wl_addr.size()-1], wl_data[wl_data.size()-1]}, {16'h0010, 18'd3});
    chk("badop_sticky", err, 1'b1);

    // Reset in the middle of a 4-word LOAD, then a fresh 1-word LOAD.
    do_reset();
    send({14'd0, OPL}, 0);
    send(18'h00100, 0);
    send(18'd4, 0);
    send(18'h000A1, 0);
    send(18'h000A2, 0);
    do_reset();
    s = wl_addr.size();
    pay = '{18'h00055};
    load(16'h0200, 0, 1'b1);
    settle();
    chk("abort_count", wl_addr.size() - s, 1);
    if (wl_addr.size() >= s + 1)
      chk("abort_write", {wl_addr[s], wl_data[s]}, {16'h0200, 18'h00055});
`ifdef ACCEL_LOADER_CHECKSUM_EN
    chk("bad_trailer_err", err, 1'b1);
`else
    chk("abort_err", err, 1'b0);
`endif

    // Randomized command mix checked by the model.
    for (int it = 0; it < 60; it++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 3) begin
        pay.delete();
        d = $urandom_range(0, 6);
        for (int i = 0; i < d; i++) pay.push_back(18'($urandom));
        load(16'($urandom), 2, 1'($urandom_range(0, 3) == 0));
      end else if (sel <= 5) begin
        send({14'($urandom), OPC}, pick_gap(2));
        for (int i = 0; i < 6; i++) send(18'($urandom), pick_gap(2));
      end else if (sel <= 7) begin
        send({14'($urandom), OPR}, pick_gap(2));
        d = $urandom_range(1, 8);
        for (int c = 1; c <= d; c++) begin
          @(negedge clk);
          accel_done = (c == d);
        end
      end else if (sel == 8) begin
        send({14'($urandom), ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(4, 15))}, 0);
      end else begin
        do_reset();
      end
    end
    settle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
